// File: rtl/shift_right_unit_pkg.sv
// Shared encodings and FSM state type for the multi-cycle right shifter.
package shift_right_unit_pkg;

  localparam logic [1:0] SHR_OP_SRL  = 2'b00;
  localparam logic [1:0] SHR_OP_SRA  = 2'b01;
  localparam logic [1:0] SHR_OP_ROTR = 2'b10;

  localparam int SHR_STAGES = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } shr_state_e;

endpackage

// File: rtl/shift_right_stage.sv
// One binary stage of the right shifter: shift by 2^idx_i when en_i, with op-dependent fill.
// SHIFT_RIGHT_ROTR_EN enables the rotate fill; otherwise ROTR falls back to zero fill.
module shift_right_stage
  import shift_right_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [2:0]       idx_i,
  input  logic             en_i,
  input  logic [1:0]       op_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0]   fill;
  logic [5:0]         amt;
  logic [2*WIDTH-1:0] ext;

  always_comb begin
    fill = (op_i == SHR_OP_SRA && sign_i) ? '1 : '0;
`ifdef SHIFT_RIGHT_ROTR_EN
    // Placing the operand itself above it makes the shifted-out bits wrap to the MSB end.
    if (op_i == SHR_OP_ROTR) fill = data_i;
`endif
    amt    = 6'd1 << idx_i;
    ext    = {fill, data_i} >> amt;
    data_o = en_i ? ext[WIDTH-1:0] : data_i;
  end

endmodule

// File: rtl/shift_right_unit.sv
// Multi-cycle right shifter (SRL/SRA/optional ROTR), one binary stage per cycle, valid/ready both sides.
// Rotate support is controlled by SHIFT_RIGHT_ROTR_EN (see shift_right_stage).
module shift_right_unit
  import shift_right_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_sa,
  input  logic [1:0]               in_op,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data
);

  shr_state_e               state_q;
  logic [2:0]               cnt_q;
  logic [WIDTH-1:0]         data_q;
  logic [WIDTH-1:0]         data_d;
  logic [$clog2(WIDTH)-1:0] sa_q;
  logic [1:0]               op_q;
  logic                     sign_q;
  logic [WIDTH-1:0]         out_data_q;
  logic                     out_valid_q;

  shift_right_stage #(.WIDTH(WIDTH)) u_stage (
    .data_i (data_q),
    .idx_i  (cnt_q),
    .en_i   (sa_q[cnt_q]),
    .op_i   (op_q),
    .sign_i (sign_q),
    .data_o (data_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      sa_q        <= '0;
      op_q        <= '0;
      sign_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid) begin
          data_q  <= in_data;
          sa_q    <= in_sa;
          op_q    <= in_op;
          sign_q  <= in_data[WIDTH-1];
          cnt_q   <= '0;
          state_q <= ST_BUSY;
        end
        ST_BUSY: begin
          data_q <= data_d;
          cnt_q  <= cnt_q + 3'd1;
          // No early exit: every stage runs even when its sa bit is clear.
          if (cnt_q == 3'(SHR_STAGES - 1)) begin
            out_data_q  <= data_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_shift_right_unit.sv
// Self-checking bench for shift_right_unit: vector table, random ops, backpressure, flush and reset cases.
module tb_shift_right_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_sa;
  logic [1:0]  in_op;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] d;
    logic [4:0]  sa;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  shift_right_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sa(in_sa), .in_op(in_op),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shr(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sa);
    int s;
    s = int'(sa);
    case (op)
      2'b01: ref_shr = $signed(d) >>> s;
`ifdef SHIFT_RIGHT_ROTR_EN
      2'b10: ref_shr = (d >> s) | (d << (32 - s));
`endif
      default: ref_shr = d >> s;
    endcase
  endfunction

  // Scoreboard: pop on each output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_output", out_data, 32'hx);
      else check("out_data", out_data, exp_q.pop_front());
    end
  end

  task automatic wait_idle();
    int w = 0;
    while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
  endtask

  // Accept on the next edge, push expectation, return once out_valid is seen.
  task automatic accept_and_wait(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sa,
                                 input logic [31:0] exp);
    int lat;
    wait_idle();
    in_op = op; in_data = d; in_sa = sa; in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(exp);
    #1;
    in_valid = 1'b0; in_data = $urandom; in_sa = 5'($urandom); in_op = 2'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("latency", 32'(lat), 32'd5);
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sa,
                      input logic [31:0] exp);
    accept_and_wait(op, d, sa, exp);
    @(posedge clk); #1;
  endtask

  task automatic watch_no_valid(input string nm, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check(nm, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, hold;
    logic [4:0]  sa;
    logic [1:0]  op;

    tbl[0]  = '{2'b00, 32'h8000_0000, 5'd31, 32'h0000_0001};
    tbl[1]  = '{2'b01, 32'h8000_0000, 5'd4,  32'hF800_0000};
    tbl[2]  = '{2'b01, 32'h7FFF_FFFF, 5'd4,  32'h07FF_FFFF};
    tbl[4]  = '{2'b11, 32'h0000_0010, 5'd4,  32'h0000_0001};
    tbl[5]  = '{2'b01, 32'h1234_5678, 5'd0,  32'h1234_5678};
    tbl[6]  = '{2'b00, 32'hDEAD_BEEF, 5'd8,  32'h00DE_ADBE};
    tbl[7]  = '{2'b01, 32'hDEAD_BEEF, 5'd8,  32'hFFDE_ADBE};
    tbl[8]  = '{2'b01, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    tbl[9]  = '{2'b00, 32'hFFFF_FFFF, 5'd16, 32'h0000_FFFF};
`ifdef SHIFT_RIGHT_ROTR_EN
    tbl[3]  = '{2'b10, 32'h0000_0001, 5'd1,  32'h8000_0000};
    tbl[10] = '{2'b10, 32'h1234_5678, 5'd4,  32'h8123_4567};
    tbl[11] = '{2'b10, 32'h0000_000F, 5'd31, 32'h0000_001E};
`else
    tbl[3]  = '{2'b10, 32'h0000_0001, 5'd1,  32'h0000_0000};
    tbl[10] = '{2'b10, 32'h1234_5678, 5'd4,  32'h0123_4567};
    tbl[11] = '{2'b10, 32'h0000_000F, 5'd31, 32'h0000_0000};
`endif

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_data = '0; in_sa = '0; in_op = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);

    foreach (tbl[i]) send(tbl[i].op, tbl[i].d, tbl[i].sa, tbl[i].exp);

    for (int i = 0; i < 10; i++) begin
      d = $urandom; sa = 5'($urandom); op = 2'($urandom);
      send(op, d, sa, ref_shr(op, d, sa));
    end

    // Backpressure: result held stable with out_ready low, then back-to-back accept.
    out_ready = 1'b0;
    accept_and_wait(2'b01, 32'h8765_4321, 5'd12, 32'hFFF8_7654);
    hold = out_data;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_out_data", out_data, hold);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_after_hs", {31'd0, in_ready}, 32'd1);
    send(2'b00, 32'hF000_0000, 5'd28, 32'h0000_000F);

    // Flush during the third BUSY cycle.
    in_op = 2'b00; in_data = 32'hAAAA_AAAA; in_sa = 5'd3; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_idle", {31'd0, in_ready}, 32'd1);
    watch_no_valid("flush_no_valid", 8);

    // Asynchronous reset mid-BUSY.
    in_op = 2'b01; in_data = 32'h8000_0001; in_sa = 5'd2; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("rst_mid_idle", {31'd0, in_ready}, 32'd1);
    check("rst_mid_out_data", out_data, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    watch_no_valid("rst_mid_no_valid", 8);

    // flush together with in_valid in IDLE: nothing accepted.
    in_op = 2'b00; in_data = 32'h0000_0100; in_sa = 5'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    check("flush_vs_accept", {31'd0, in_ready}, 32'd1);
    watch_no_valid("flush_vs_accept_no_valid", 8);

    send(2'b01, 32'h4000_0000, 5'd30, 32'h0000_0001);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
